// File: rtl/pcie_ep_cfg_pkg.sv
// Shared types, register offsets and helpers for the endpoint Type-0 config responder.
package pcie_ep_cfg_pkg;

  typedef enum logic [2:0] {
    CPL_SC = 3'b000,
    CPL_UR = 3'b001
  } cpl_status_e;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    CPL
  } state_e;

  localparam logic [9:0] DW_ID         = 10'h000;
  localparam logic [9:0] DW_CMD_STATUS = 10'h001;
  localparam logic [9:0] DW_CLASS_REV  = 10'h002;
  localparam logic [9:0] DW_BAR0       = 10'h004;
  localparam logic [9:0] DW_CAP_PTR    = 10'h00D;
  localparam logic [9:0] DW_INT        = 10'h00F;
  localparam logic [9:0] DW_MSI_CTL    = 10'h014;
  localparam logic [9:0] DW_MSI_ADDR   = 10'h015;
  localparam logic [9:0] DW_MSI_DATA   = 10'h016;

  localparam logic [7:0] MSI_CAP_PTR = 8'h50;
  localparam logic [7:0] MSI_CAP_ID  = 8'h05;

  // Byte-enable merge of write data into an existing DW value.
  function automatic logic [31:0] be_merge(input logic [31:0] old_val,
                                           input logic [31:0] wdata,
                                           input logic [3:0]  be);
    logic [31:0] r;
    r = old_val;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) r[8*i +: 8] = wdata[8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/pcie_ep_cfg_msi_cap.sv
// MSI capability (single vector, 32-bit address) storage and read mux for the config responder.
module pcie_ep_cfg_msi_cap
  import pcie_ep_cfg_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_en_i,
  input  logic [9:0]  reg_num_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        msi_enable_o,
  output logic [31:0] msi_addr_o,
  output logic [15:0] msi_data_o
);

  logic        enable_q;
  logic [31:2] addr_q;
  logic [15:0] data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enable_q <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
    end else if (wr_en_i) begin
      case (reg_num_i)
        DW_MSI_CTL: begin
          if (be_i[2]) enable_q <= wdata_i[16];
        end
        DW_MSI_ADDR: begin
          if (be_i[0]) addr_q[7:2]   <= wdata_i[7:2];
          if (be_i[1]) addr_q[15:8]  <= wdata_i[15:8];
          if (be_i[2]) addr_q[23:16] <= wdata_i[23:16];
          if (be_i[3]) addr_q[31:24] <= wdata_i[31:24];
        end
        DW_MSI_DATA: begin
          if (be_i[0]) data_q[7:0]  <= wdata_i[7:0];
          if (be_i[1]) data_q[15:8] <= wdata_i[15:8];
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    rdata_o = '0;
    case (reg_num_i)
      DW_MSI_CTL:  rdata_o = {15'b0, enable_q, 8'h00, MSI_CAP_ID};
      DW_MSI_ADDR: rdata_o = {addr_q, 2'b00};
      DW_MSI_DATA: rdata_o = {16'h0000, data_q};
      default:     rdata_o = '0;
    endcase
  end

  assign msi_enable_o = enable_q;
  assign msi_addr_o   = {addr_q, 2'b00};
  assign msi_data_o   = data_q;

endmodule

// File: rtl/pcie_ep_cfg_responder.sv
// Endpoint Type-0 config space completer: one completion per CfgRd0/CfgWr0 request.
// Optional MSI capability is built when PCIE_EP_MSI_CAP_EN is defined.
module pcie_ep_cfg_responder
  import pcie_ep_cfg_pkg::*;
#(
  parameter logic [15:0] VENDOR_ID      = 16'h1234,
  parameter logic [15:0] DEVICE_ID      = 16'h0001,
  parameter logic [31:0] CLASS_REV      = 32'h0580_0001,
  parameter int unsigned BAR0_SIZE_LOG2 = 12
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_write_i,
  input  logic [9:0]  req_reg_num_i,
  input  logic [2:0]  req_func_num_i,
  input  logic [12:0] req_bus_dev_i,
  input  logic [3:0]  req_be_i,
  input  logic [31:0] req_wdata_i,
  input  logic [7:0]  req_tag_i,
  input  logic [15:0] req_requester_id_i,
  output logic        cpl_valid_o,
  input  logic        cpl_ready_i,
  output logic [2:0]  cpl_status_o,
  output logic        cpl_has_data_o,
  output logic [31:0] cpl_data_o,
  output logic [7:0]  cpl_tag_o,
  output logic [15:0] cpl_requester_id_o,
  output logic [15:0] cpl_completer_id_o,
  output logic        cmd_mem_en_o,
  output logic        cmd_bus_master_en_o,
  output logic        cmd_intx_disable_o,
  output logic [31:0] bar0_base_o,
  input  logic        intx_pending_i,
  output logic        msi_enable_o,
  output logic [31:0] msi_addr_o,
  output logic [15:0] msi_data_o
);

  localparam logic [31:0] BAR0_MASK = ~((32'd1 << BAR0_SIZE_LOG2) - 32'd1);

  state_e      state_q;
  logic        req_ready_q;
  logic        write_q;
  logic [9:0]  reg_num_q;
  logic [2:0]  func_q;
  logic [12:0] bus_dev_in_q;
  logic [3:0]  be_q;
  logic [31:0] wdata_q;
  logic [7:0]  tag_q;
  logic [15:0] rid_q;
  logic [12:0] bus_dev_q;
  logic        cpl_valid_q;
  cpl_status_e cpl_status_q;
  logic        cpl_has_data_q;
  logic [31:0] cpl_data_q;
  logic [7:0]  cpl_tag_q;
  logic [15:0] cpl_rid_q;
  logic [15:0] cpl_cid_q;
  logic        cmd_mem_q;
  logic        cmd_bm_q;
  logic        cmd_intx_q;
  logic [31:0] bar0_q;
  logic [7:0]  int_line_q;
  logic [31:0] rd_data_d;
  logic [31:0] msi_rdata;
  logic        access_wr;

  assign access_wr = (state_q == ACCESS) && write_q && (func_q == 3'd0);

`ifdef PCIE_EP_MSI_CAP_EN
  localparam logic [7:0] CAP_PTR  = MSI_CAP_PTR;
  localparam logic       CAP_LIST = 1'b1;

  pcie_ep_cfg_msi_cap u_msi_cap (
    .clk          (clk),
    .rst_n        (rst_n),
    .wr_en_i      (access_wr),
    .reg_num_i    (reg_num_q),
    .be_i         (be_q),
    .wdata_i      (wdata_q),
    .rdata_o      (msi_rdata),
    .msi_enable_o (msi_enable_o),
    .msi_addr_o   (msi_addr_o),
    .msi_data_o   (msi_data_o)
  );
`else
  localparam logic [7:0] CAP_PTR  = 8'h00;
  localparam logic       CAP_LIST = 1'b0;

  assign msi_rdata    = '0;
  assign msi_enable_o = 1'b0;
  assign msi_addr_o   = '0;
  assign msi_data_o   = '0;
`endif

  // Read mux sees register values from before any write in the same access.
  always_comb begin
    rd_data_d = '0;
    case (reg_num_q)
      DW_ID:         rd_data_d = {DEVICE_ID, VENDOR_ID};
      DW_CMD_STATUS: rd_data_d = {11'b0, CAP_LIST, intx_pending_i, 3'b0,
                                  5'b0, cmd_intx_q, 7'b0, cmd_bm_q, cmd_mem_q, 1'b0};
      DW_CLASS_REV:  rd_data_d = CLASS_REV;
      DW_BAR0:       rd_data_d = bar0_q;
      DW_CAP_PTR:    rd_data_d = {24'h0, CAP_PTR};
      DW_INT:        rd_data_d = {16'h0, 8'h01, int_line_q};
      default:       rd_data_d = msi_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      req_ready_q    <= 1'b1;
      write_q        <= 1'b0;
      reg_num_q      <= '0;
      func_q         <= '0;
      bus_dev_in_q   <= '0;
      be_q           <= '0;
      wdata_q        <= '0;
      tag_q          <= '0;
      rid_q          <= '0;
      bus_dev_q      <= '0;
      cpl_valid_q    <= 1'b0;
      cpl_status_q   <= CPL_SC;
      cpl_has_data_q <= 1'b0;
      cpl_data_q     <= '0;
      cpl_tag_q      <= '0;
      cpl_rid_q      <= '0;
      cpl_cid_q      <= '0;
      cmd_mem_q      <= 1'b0;
      cmd_bm_q       <= 1'b0;
      cmd_intx_q     <= 1'b0;
      bar0_q         <= '0;
      int_line_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid_i && req_ready_q) begin
            write_q      <= req_write_i;
            reg_num_q    <= req_reg_num_i;
            func_q       <= req_func_num_i;
            bus_dev_in_q <= req_bus_dev_i;
            be_q         <= req_be_i;
            wdata_q      <= req_wdata_i;
            tag_q        <= req_tag_i;
            rid_q        <= req_requester_id_i;
            req_ready_q  <= 1'b0;
            state_q      <= ACCESS;
          end
        end
        ACCESS: begin
          cpl_valid_q <= 1'b1;
          cpl_tag_q   <= tag_q;
          cpl_rid_q   <= rid_q;
          state_q     <= CPL;
          if (func_q != 3'd0) begin
            cpl_status_q   <= CPL_UR;
            cpl_has_data_q <= 1'b0;
            cpl_data_q     <= '0;
            cpl_cid_q      <= {bus_dev_q, 3'b000};
          end else if (write_q) begin
            // Every function-0 write refreshes our bus/device number, even with no byte enables.
            bus_dev_q      <= bus_dev_in_q;
            cpl_status_q   <= CPL_SC;
            cpl_has_data_q <= 1'b0;
            cpl_data_q     <= '0;
            cpl_cid_q      <= {bus_dev_in_q, 3'b000};
            case (reg_num_q)
              DW_CMD_STATUS: begin
                if (be_q[0]) {cmd_bm_q, cmd_mem_q} <= wdata_q[2:1];
                if (be_q[1]) cmd_intx_q <= wdata_q[10];
              end
              DW_BAR0: bar0_q <= be_merge(bar0_q, wdata_q, be_q) & BAR0_MASK;
              DW_INT: begin
                if (be_q[0]) int_line_q <= wdata_q[7:0];
              end
              default: ;
            endcase
          end else begin
            cpl_status_q   <= CPL_SC;
            cpl_has_data_q <= 1'b1;
            cpl_data_q     <= rd_data_d;
            cpl_cid_q      <= {bus_dev_q, 3'b000};
          end
        end
        CPL: begin
          if (cpl_ready_i) begin
            cpl_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready_o         = req_ready_q;
  assign cpl_valid_o         = cpl_valid_q;
  assign cpl_status_o        = cpl_status_q;
  assign cpl_has_data_o      = cpl_has_data_q;
  assign cpl_data_o          = cpl_data_q;
  assign cpl_tag_o           = cpl_tag_q;
  assign cpl_requester_id_o  = cpl_rid_q;
  assign cpl_completer_id_o  = cpl_cid_q;
  assign cmd_mem_en_o        = cmd_mem_q;
  assign cmd_bus_master_en_o = cmd_bm_q;
  assign cmd_intx_disable_o  = cmd_intx_q;
  assign bar0_base_o         = bar0_q;

endmodule

// File: tb/tb_pcie_ep_cfg_responder.sv
// Scoreboard bench for pcie_ep_cfg_responder: directed config requests, queued expectations,
// independent completion monitor. Expected values follow PCIE_EP_MSI_CAP_EN when defined.
module tb_pcie_ep_cfg_responder;

`ifdef PCIE_EP_MSI_CAP_EN
  localparam bit MSI = 1'b1;
`else
  localparam bit MSI = 1'b0;
`endif

  typedef struct {
    logic [2:0]  st;
    logic        hd;
    logic [31:0] data;
    logic [7:0]  tag;
    logic [15:0] rid;
    logic [15:0] cid;
    int          acc;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [9:0]  req_reg_num;
  logic [2:0]  req_func_num;
  logic [12:0] req_bus_dev;
  logic [3:0]  req_be;
  logic [31:0] req_wdata;
  logic [7:0]  req_tag;
  logic [15:0] req_requester_id;
  logic        cpl_valid;
  logic        cpl_ready;
  logic [2:0]  cpl_status;
  logic        cpl_has_data;
  logic [31:0] cpl_data;
  logic [7:0]  cpl_tag;
  logic [15:0] cpl_requester_id;
  logic [15:0] cpl_completer_id;
  logic        cmd_mem_en;
  logic        cmd_bus_master_en;
  logic        cmd_intx_disable;
  logic [31:0] bar0_base;
  logic        intx_pending;
  logic        msi_enable;
  logic [31:0] msi_addr;
  logic [15:0] msi_data;

  exp_t expQ[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  pcie_ep_cfg_responder dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .req_valid_i         (req_valid),
    .req_ready_o         (req_ready),
    .req_write_i         (req_write),
    .req_reg_num_i       (req_reg_num),
    .req_func_num_i      (req_func_num),
    .req_bus_dev_i       (req_bus_dev),
    .req_be_i            (req_be),
    .req_wdata_i         (req_wdata),
    .req_tag_i           (req_tag),
    .req_requester_id_i  (req_requester_id),
    .cpl_valid_o         (cpl_valid),
    .cpl_ready_i         (cpl_ready),
    .cpl_status_o        (cpl_status),
    .cpl_has_data_o      (cpl_has_data),
    .cpl_data_o          (cpl_data),
    .cpl_tag_o           (cpl_tag),
    .cpl_requester_id_o  (cpl_requester_id),
    .cpl_completer_id_o  (cpl_completer_id),
    .cmd_mem_en_o        (cmd_mem_en),
    .cmd_bus_master_en_o (cmd_bus_master_en),
    .cmd_intx_disable_o  (cmd_intx_disable),
    .bar0_base_o         (bar0_base),
    .intx_pending_i      (intx_pending),
    .msi_enable_o        (msi_enable),
    .msi_addr_o          (msi_addr),
    .msi_data_o          (msi_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: each completion handshake is compared against the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n && cpl_valid && cpl_ready) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected_cpl", {24'h0, cpl_tag}, 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = expQ.pop_front();
        checkOutput("cpl_status",   {29'h0, cpl_status}, {29'h0, e.st});
        checkOutput("cpl_has_data", {31'h0, cpl_has_data}, {31'h0, e.hd});
        checkOutput("cpl_data",     cpl_data, e.data);
        checkOutput("cpl_tag",      {24'h0, cpl_tag}, {24'h0, e.tag});
        checkOutput("cpl_req_id",   {16'h0, cpl_requester_id}, {16'h0, e.rid});
        checkOutput("cpl_cpl_id",   {16'h0, cpl_completer_id}, {16'h0, e.cid});
        checkOutput("cpl_latency",  cyc, e.acc + 1);
      end
    end
  end

  task automatic applyStimulus(input bit wr, input logic [9:0] rn, input logic [2:0] fn,
                               input logic [12:0] bd, input logic [3:0] be,
                               input logic [31:0] wd, input logic [7:0] tag,
                               input logic [2:0] est, input logic ehd,
                               input logic [31:0] edata, input logic [15:0] ecid,
                               input bit push);
    int   n;
    exp_t e;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      checkOutput("req_ready_timeout", 32'h0, 32'h1);
    end else begin
      req_valid        = 1'b1;
      req_write        = wr;
      req_reg_num      = rn;
      req_func_num     = fn;
      req_bus_dev      = bd;
      req_be           = be;
      req_wdata        = wd;
      req_tag          = tag;
      req_requester_id = {8'h01, tag};
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      if (push) begin
        e.st = est; e.hd = ehd; e.data = edata; e.tag = tag;
        e.rid = {8'h01, tag}; e.cid = ecid; e.acc = cyc;
        expQ.push_back(e);
      end
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (expQ.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (expQ.size() != 0) begin
      checkOutput("drain_timeout", expQ.size(), 0);
      expQ.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    int n;
    rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_reg_num = '0; req_func_num = '0;
    req_bus_dev = '0; req_be = '0; req_wdata = '0; req_tag = '0; req_requester_id = '0;
    cpl_ready = 1'b1; intx_pending = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst_req_ready", {31'h0, req_ready}, 32'h1);
    checkOutput("rst_cpl_valid", {31'h0, cpl_valid}, 32'h0);
    checkOutput("rst_cmd", {29'h0, cmd_mem_en, cmd_bus_master_en, cmd_intx_disable}, 32'h0);
    checkOutput("rst_bar0", bar0_base, 32'h0);
    checkOutput("rst_cpl_id", {16'h0, cpl_completer_id}, 32'h0);
    rst_n = 1'b1;

    applyStimulus(0, 10'h000, 3'd0, 13'h000, 4'hF, 32'h0, 8'h5A, 3'b000, 1, 32'h0001_1234, 16'h0000, 1);
    applyStimulus(1, 10'h004, 3'd0, 13'h011, 4'hF, 32'hFFFF_FFFF, 8'h01, 3'b000, 0, 32'h0, 16'h0088, 1);
    applyStimulus(0, 10'h004, 3'd0, 13'h011, 4'hF, 32'h0, 8'h02, 3'b000, 1, 32'hFFFF_F000, 16'h0088, 1);
    drain();
    checkOutput("bar0_all_ones", bar0_base, 32'hFFFF_F000);

    applyStimulus(1, 10'h001, 3'd0, 13'h0A8, 4'hF, 32'h0000_0406, 8'h03, 3'b000, 0, 32'h0, 16'h0540, 1);
    drain();
    checkOutput("cmd_after_wr", {29'h0, cmd_mem_en, cmd_bus_master_en, cmd_intx_disable}, 32'h7);

    intx_pending = 1'b1;
    applyStimulus(0, 10'h001, 3'd0, 13'h0A8, 4'hF, 32'h0, 8'h04, 3'b000, 1,
                  32'h0008_0406 | (MSI ? 32'h0010_0000 : 32'h0), 16'h0540, 1);
    drain();
    intx_pending = 1'b0;

    applyStimulus(0, 10'h000, 3'd1, 13'h1FFF, 4'hF, 32'h0, 8'h05, 3'b001, 0, 32'h0, 16'h0540, 1);
    applyStimulus(0, 10'h200, 3'd0, 13'h0A8, 4'hF, 32'h0, 8'h06, 3'b000, 1, 32'h0, 16'h0540, 1);
    applyStimulus(1, 10'h001, 3'd0, 13'h033, 4'h0, 32'h0, 8'h07, 3'b000, 0, 32'h0, 16'h0198, 1);
    drain();
    checkOutput("cmd_be0_kept", {29'h0, cmd_mem_en, cmd_bus_master_en, cmd_intx_disable}, 32'h7);

    applyStimulus(1, 10'h00F, 3'd0, 13'h033, 4'h1, 32'hFFFF_FFFF, 8'h08, 3'b000, 0, 32'h0, 16'h0198, 1);
    applyStimulus(0, 10'h00F, 3'd0, 13'h033, 4'hF, 32'h0, 8'h09, 3'b000, 1, 32'h0000_01FF, 16'h0198, 1);
    applyStimulus(0, 10'h00D, 3'd0, 13'h033, 4'hF, 32'h0, 8'h0A, 3'b000, 1,
                  MSI ? 32'h0000_0050 : 32'h0, 16'h0198, 1);
    applyStimulus(1, 10'h004, 3'd0, 13'h033, 4'h8, 32'h1234_5678, 8'h0B, 3'b000, 0, 32'h0, 16'h0198, 1);
    drain();
    checkOutput("bar0_byte3", bar0_base, 32'h12FF_F000);

    applyStimulus(0, 10'h002, 3'd0, 13'h033, 4'hF, 32'h0, 8'h0C, 3'b000, 1, 32'h0580_0001, 16'h0198, 1);
    applyStimulus(0, 10'h003, 3'd0, 13'h033, 4'hF, 32'h0, 8'h0D, 3'b000, 1, 32'h0, 16'h0198, 1);
    applyStimulus(1, 10'h015, 3'd0, 13'h033, 4'hF, 32'hFEE0_1003, 8'h0E, 3'b000, 0, 32'h0, 16'h0198, 1);
    applyStimulus(1, 10'h014, 3'd0, 13'h033, 4'h4, 32'h0001_0000, 8'h0F, 3'b000, 0, 32'h0, 16'h0198, 1);
    applyStimulus(1, 10'h016, 3'd0, 13'h033, 4'h3, 32'h0000_ABCD, 8'h10, 3'b000, 0, 32'h0, 16'h0198, 1);
    drain();
    checkOutput("msi_addr", msi_addr, MSI ? 32'hFEE0_1000 : 32'h0);
    checkOutput("msi_enable", {31'h0, msi_enable}, MSI ? 32'h1 : 32'h0);
    checkOutput("msi_data", {16'h0, msi_data}, MSI ? 32'h0000_ABCD : 32'h0);
    applyStimulus(0, 10'h014, 3'd0, 13'h033, 4'hF, 32'h0, 8'h11, 3'b000, 1,
                  MSI ? 32'h0001_0005 : 32'h0, 16'h0198, 1);

    // Function 1 write: UR, no command change and no bus/device capture.
    applyStimulus(1, 10'h001, 3'd1, 13'h1FFF, 4'hF, 32'h0, 8'h12, 3'b001, 0, 32'h0, 16'h0198, 1);
    drain();
    checkOutput("cmd_func1_kept", {29'h0, cmd_mem_en, cmd_bus_master_en, cmd_intx_disable}, 32'h7);

    cpl_ready = 1'b0;
    applyStimulus(0, 10'h000, 3'd0, 13'h033, 4'hF, 32'h0, 8'h77, 3'b000, 1, 32'h0, 16'h0, 0);
    n = 0;
    while (!cpl_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("hold_cpl_valid", {31'h0, cpl_valid}, 32'h1);
      checkOutput("hold_cpl_data", cpl_data, 32'h0001_1234);
      checkOutput("hold_cpl_tag", {24'h0, cpl_tag}, 32'h77);
      checkOutput("hold_req_ready", {31'h0, req_ready}, 32'h0);
    end
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_cpl_valid", {31'h0, cpl_valid}, 32'h0);
    checkOutput("midrst_req_ready", {31'h0, req_ready}, 32'h1);
    checkOutput("midrst_cmd", {29'h0, cmd_mem_en, cmd_bus_master_en, cmd_intx_disable}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    cpl_ready = 1'b1;

    applyStimulus(0, 10'h000, 3'd0, 13'h055, 4'hF, 32'h0, 8'h99, 3'b000, 1, 32'h0001_1234, 16'h0000, 1);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
